pug_game_sequencer: RTL and testbench

//   Game-level controller for the Magical Pug VGA pipeline. Sequences the round

---
 rtl/pug_game_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pug_game_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pug_game_sequencer.sv
// Round controller for the Magical Pug VGA game: countdown, run, pause, over.
// Motion strobes are aligned to frame boundaries; tracks the session high score.
module pug_game_sequencer #(
    parameter int SCORE_W          = 10,
    parameter int SLOW_DIV         = 3,
    parameter int FAST_DIV         = 1,
    parameter int CD_FRAMES        = 60,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_end,
    input  logic               start_pressed,
    input  logic               reset_pressed,
    input  logic               pause_pressed,
    input  logic               collision,
    input  logic               level_fast,
    input  logic [SCORE_W-1:0] score,
    output logic               game_active,
    output logic               game_reset,
    output logic               move_tick,
    output logic [1:0]         countdown,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CD    = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } st_t;

    localparam logic [7:0] CD_LAST   = 8'(CD_FRAMES - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(OVER_HOLD_FRAMES);
    localparam logic [3:0] SLOW_LAST = 4'(SLOW_DIV - 1);
    localparam logic [3:0] FAST_LAST = 4'(FAST_DIV - 1);

    st_t                cur_st;
    st_t                nxt_st;
    logic [7:0]         frame_cnt;
    logic [7:0]         frame_cnt_n;
    logic [7:0]         hold_cnt;
    logic [7:0]         hold_cnt_n;
    logic [3:0]         tick_cnt;
    logic [3:0]         tick_cnt_n;
    logic [3:0]         div_last;
    logic [1:0]         cd_n;
    logic [SCORE_W-1:0] hi_n;
    logic               rec_n;
    logic               greset_n;
    logic               tick_n;

    assign state = cur_st;

    // Next-state and next-output logic; reset_pressed overrides everything,
    // then per-state priority collision > pause > start/frame handling.
    always_comb begin
        nxt_st      = cur_st;
        frame_cnt_n = frame_cnt;
        hold_cnt_n  = hold_cnt;
        tick_cnt_n  = tick_cnt;
        cd_n        = countdown;
        hi_n        = high_score;
        rec_n       = new_record;
        greset_n    = 1'b0;
        tick_n      = 1'b0;
        div_last    = level_fast ? FAST_LAST : SLOW_LAST;
        if (reset_pressed) begin
            nxt_st   = S_IDLE;
            greset_n = 1'b1;
            cd_n     = 2'd0;
            rec_n    = 1'b0;
        end else begin
            case (cur_st)
                S_IDLE: begin
                    if (start_pressed) begin
                        nxt_st      = S_CD;
                        cd_n        = 2'd3;
                        frame_cnt_n = 8'd0;
                        greset_n    = 1'b1;
                    end
                end
                S_CD: begin
                    if (frame_end) begin
                        if (frame_cnt == CD_LAST) begin
                            frame_cnt_n = 8'd0;
                            if (countdown == 2'd1) begin
                                nxt_st     = S_RUN;
                                cd_n       = 2'd0;
                                tick_cnt_n = 4'd0;
                            end else begin
                                cd_n = countdown - 2'd1;
                            end
                        end else begin
                            frame_cnt_n = frame_cnt + 8'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (collision) begin
                        nxt_st     = S_OVER;
                        hold_cnt_n = 8'd0;
                        if (score > high_score) begin
                            hi_n  = score;
                            rec_n = 1'b1;
                        end
                    end else if (pause_pressed) begin
                        nxt_st = S_PAUSE;
                    end else if (frame_end) begin
                        // >= also catches a count left above a newly smaller divider
                        if (tick_cnt >= div_last) begin
                            tick_n     = 1'b1;
                            tick_cnt_n = 4'd0;
                        end else begin
                            tick_cnt_n = tick_cnt + 4'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (pause_pressed) begin
                        nxt_st = S_RUN;
                    end
                end
                S_OVER: begin
                    if (start_pressed && hold_cnt >= HOLD_MAX) begin
                        nxt_st      = S_CD;
                        cd_n        = 2'd3;
                        frame_cnt_n = 8'd0;
                        rec_n       = 1'b0;
                        greset_n    = 1'b1;
                    end else if (frame_end && hold_cnt < HOLD_MAX) begin
                        hold_cnt_n = hold_cnt + 8'd1;
                    end
                end
                default: begin
                    nxt_st = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st      <= S_IDLE;
            frame_cnt   <= 8'd0;
            hold_cnt    <= 8'd0;
            tick_cnt    <= 4'd0;
            countdown   <= 2'd0;
            high_score  <= '0;
            new_record  <= 1'b0;
            game_reset  <= 1'b0;
            move_tick   <= 1'b0;
            game_active <= 1'b0;
        end else begin
            cur_st      <= nxt_st;
            frame_cnt   <= frame_cnt_n;
            hold_cnt    <= hold_cnt_n;
            tick_cnt    <= tick_cnt_n;
            countdown   <= cd_n;
            high_score  <= hi_n;
            new_record  <= rec_n;
            game_reset  <= greset_n;
            move_tick   <= tick_n;
            game_active <= (nxt_st == S_RUN);
        end
    end

endmodule

// File: tb/tb_pug_game_sequencer.sv
// Bench for pug_game_sequencer: phase-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pug_game_sequencer;

    localparam int SW   = 10;
    localparam int SD   = 3;
    localparam int FD   = 1;
    localparam int CDF  = 2;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_end = 1'b0;
    logic          start_pressed = 1'b0;
    logic          reset_pressed = 1'b0;
    logic          pause_pressed = 1'b0;
    logic          collision = 1'b0;
    logic          level_fast = 1'b0;
    logic [SW-1:0] score = '0;
    logic          game_active;
    logic          game_reset;
    logic          move_tick;
    logic [1:0]    countdown;
    logic [2:0]    state;
    logic [SW-1:0] high_score;
    logic          new_record;

    int errors = 0;
    int checks = 0;
    int ticks_seen = 0;
    bit cmp_en = 1'b0;

    pug_game_sequencer #(
        .SCORE_W(SW), .SLOW_DIV(SD), .FAST_DIV(FD),
        .CD_FRAMES(CDF), .OVER_HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end),
        .start_pressed(start_pressed), .reset_pressed(reset_pressed),
        .pause_pressed(pause_pressed), .collision(collision),
        .level_fast(level_fast), .score(score),
        .game_active(game_active), .game_reset(game_reset),
        .move_tick(move_tick), .countdown(countdown), .state(state),
        .high_score(high_score), .new_record(new_record)
    );

    always #5 clk = ~clk;

    function automatic void chkn(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endfunction

    // Reference model: phase 0..4, frames seen in countdown, frames since last tick
    int m_phase = 0;
    int m_cd_seen = 0;
    int m_since = 0;
    int m_hold = 0;
    int m_hi = 0;
    bit m_rec = 1'b0;
    bit e_reset = 1'b0;
    bit e_tick = 1'b0;

    function automatic void begin_cd();
        m_phase   = 1;
        m_cd_seen = 0;
        m_rec     = 1'b0;
        e_reset   = 1'b1;
    endfunction

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        e_reset = 1'b0;
        e_tick  = 1'b0;
        if (reset) begin
            m_phase = 0; m_cd_seen = 0; m_since = 0;
            m_hold = 0; m_hi = 0; m_rec = 1'b0;
        end else if (reset_pressed) begin
            m_phase = 0; m_rec = 1'b0; e_reset = 1'b1;
        end else begin
            case (m_phase)
                0: if (start_pressed) begin_cd();
                1: if (frame_end) begin
                    m_cd_seen++;
                    if (m_cd_seen == 3 * CDF) begin
                        m_phase = 2; m_since = 0;
                    end
                end
                2: if (collision) begin
                    m_phase = 4; m_hold = 0;
                    if (int'(score) > m_hi) begin
                        m_hi = int'(score); m_rec = 1'b1;
                    end
                end else if (pause_pressed) begin
                    m_phase = 3;
                end else if (frame_end) begin
                    m_since++;
                    if (m_since >= (level_fast ? FD : SD)) begin
                        e_tick = 1'b1; m_since = 0;
                    end
                end
                3: if (pause_pressed) m_phase = 2;
                4: if (start_pressed && m_hold >= HOLD) begin_cd();
                   else if (frame_end && m_hold < HOLD) m_hold++;
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model, just after the edge.
    always @(posedge clk) begin
        #1;
        if (move_tick === 1'b1) ticks_seen++;
        if (cmp_en) begin
            chkn("m_state", 32'(state), m_phase);
            chk1("m_active", game_active, m_phase == 2);
            chk1("m_greset", game_reset, e_reset);
            chk1("m_tick", move_tick, e_tick);
            chkn("m_countdown", 32'(countdown),
                 (m_phase == 1) ? 3 - m_cd_seen / CDF : 0);
            chkn("m_high", 32'(high_score), m_hi);
            chk1("m_rec", new_record, m_rec);
            chk1("m_excl", game_reset & move_tick, 1'b0);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame();
        frame_end = 1'b1; cyc(); frame_end = 1'b0; cyc();
    endtask

    task automatic start_pulse();
        start_pressed = 1'b1; cyc(); start_pressed = 1'b0; cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (2) cyc();
        chkn("rst_state", 32'(state), 0);
        chk1("rst_active", game_active, 1'b0);
        chk1("rst_greset", game_reset, 1'b0);
        chk1("rst_tick", move_tick, 1'b0);
        chkn("rst_cd", 32'(countdown), 0);
        chkn("rst_high", 32'(high_score), 0);
        chk1("rst_rec", new_record, 1'b0);
        reset = 1'b0;
        cmp_en = 1'b1;
        cyc();

        // countdown 3->2->1->0 on frames 2,4,6
        start_pressed = 1'b1; cyc(); start_pressed = 1'b0;
        chk1("t1_greset", game_reset, 1'b1);
        chkn("t1_cd3", 32'(countdown), 3);
        chkn("t1_state_cd", 32'(state), 1);
        cyc();
        chk1("t1_greset_off", game_reset, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            frame_end = 1'b1; cyc(); frame_end = 1'b0;
            if (i == 2) chkn("t1_cd2", 32'(countdown), 2);
            if (i == 4) chkn("t1_cd1", 32'(countdown), 1);
            if (i == 6) begin
                chkn("t1_cd0", 32'(countdown), 0);
                chkn("t1_run", 32'(state), 2);
            end
            cyc();
        end

        // slow ticks every 3rd frame, then fast every frame
        t0 = ticks_seen;
        for (int i = 1; i <= 9; i++) begin
            frame_end = 1'b1; cyc(); frame_end = 1'b0;
            chk1($sformatf("t2_tick_f%0d", i), move_tick, (i % 3) == 0);
            cyc();
        end
        chkn("t2_slow_cnt", ticks_seen - t0, 3);
        level_fast = 1'b1;
        t0 = ticks_seen;
        repeat (4) frame();
        chkn("t2_fast_cnt", ticks_seen - t0, 4);

        // first game over with score 5
        score = 10'd5;
        collision = 1'b1; frame_end = 1'b1; cyc();
        collision = 1'b0; frame_end = 1'b0;
        chkn("t3_over", 32'(state), 4);
        chk1("t3_notick", move_tick, 1'b0);
        chkn("t3_hi5", 32'(high_score), 5);
        chk1("t3_rec", new_record, 1'b1);
        cyc();

        // start dropped during hold
        start_pressed = 1'b1; cyc(); start_pressed = 1'b0;
        chkn("t4_hold0", 32'(state), 4);
        chk1("t4_nogreset", game_reset, 1'b0);
        cyc();
        repeat (3) frame();
        start_pressed = 1'b1; cyc(); start_pressed = 1'b0;
        chkn("t4_hold3", 32'(state), 4);
        cyc();
        frame();
        start_pressed = 1'b1; cyc(); start_pressed = 1'b0;
        chkn("t4_cd", 32'(state), 1);
        chk1("t4_rec0", new_record, 1'b0);
        chk1("t4_greset", game_reset, 1'b1);
        cyc();
        repeat (6) frame();
        chkn("t4_run", 32'(state), 2);

        // score 7 beats 5, collision on a tick frame
        score = 10'd7;
        collision = 1'b1; frame_end = 1'b1; cyc();
        collision = 1'b0; frame_end = 1'b0;
        chkn("t3b_over", 32'(state), 4);
        chk1("t3b_notick", move_tick, 1'b0);
        chkn("t3b_hi7", 32'(high_score), 7);
        chk1("t3b_rec", new_record, 1'b1);
        cyc();

        // score 4 does not beat 7
        repeat (4) frame();
        start_pulse();
        repeat (6) frame();
        score = 10'd4;
        collision = 1'b1; frame_end = 1'b1; cyc();
        collision = 1'b0; frame_end = 1'b0;
        chkn("t3c_over", 32'(state), 4);
        chkn("t3c_hi7", 32'(high_score), 7);
        chk1("t3c_rec0", new_record, 1'b0);
        cyc();

        // pause with tick_cnt=1 freezes everything
        repeat (4) frame();
        start_pulse();
        repeat (6) frame();
        level_fast = 1'b0;
        frame();
        pause_pressed = 1'b1; cyc(); pause_pressed = 1'b0;
        chkn("t5_pause", 32'(state), 3);
        chk1("t5_inactive", game_active, 1'b0);
        cyc();
        t0 = ticks_seen;
        collision = 1'b1;
        repeat (5) frame();
        collision = 1'b0;
        chkn("t5_held", 32'(state), 3);
        chkn("t5_noticks", ticks_seen - t0, 0);
        pause_pressed = 1'b1; cyc(); pause_pressed = 1'b0;
        chkn("t5_resume", 32'(state), 2);
        cyc();
        frame_end = 1'b1; cyc(); frame_end = 1'b0;
        chk1("t5_f1_notick", move_tick, 1'b0);
        cyc();
        frame_end = 1'b1; cyc(); frame_end = 1'b0;
        chk1("t5_f2_tick", move_tick, 1'b1);
        cyc();

        // reset_pressed beats collision and start
        reset_pressed = 1'b1; collision = 1'b1; start_pressed = 1'b1;
        cyc();
        reset_pressed = 1'b0; collision = 1'b0; start_pressed = 1'b0;
        chkn("t6_idle", 32'(state), 0);
        chk1("t6_greset", game_reset, 1'b1);
        chkn("t6_hi7", 32'(high_score), 7);
        chk1("t6_inactive", game_active, 1'b0);
        cyc();

        // hard reset mid-countdown clears everything
        start_pulse();
        repeat (2) frame();
        chkn("t6_cd2", 32'(countdown), 2);
        reset = 1'b1; cyc(); reset = 1'b0;
        chkn("t6_rst_state", 32'(state), 0);
        chkn("t6_rst_cd", 32'(countdown), 0);
        chkn("t6_rst_hi", 32'(high_score), 0);
        chk1("t6_rst_greset", game_reset, 1'b0);
        chk1("t6_rst_active", game_active, 1'b0);
        chk1("t6_rst_rec", new_record, 1'b0);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
